// File: rtl/rotary_decoder.sv
// Rotary encoder front end: 2-FF sync, per-pin debounce, quadrature FSM.
// Define ROTARY_DEC_POS_EN to add the signed 8-bit detent position output.
module rotary_decoder #(
  parameter int DEB_CYCLES = 1000,
  parameter int CNT_W      = 16
) (
  input  logic clk,
  input  logic clr,
  input  logic rot_a,
  input  logic rot_b,
  input  logic push_in,
  output logic rotl,
  output logic rotr,
  output logic push
`ifdef ROTARY_DEC_POS_EN
  ,
  output logic signed [7:0] pos
`endif
);

  typedef enum logic [2:0] {
    IDLE,
    CW1,
    CW2,
    CW3,
    CCW1,
    CCW2,
    CCW3,
    ERR
  } state_e;

  // Channel bits: [0]=A, [1]=B, [2]=push; A/B idle high
  localparam logic [2:0] RST_V = 3'b011;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(DEB_CYCLES - 1);

  logic [2:0] sync1_q;
  logic [2:0] sync2_q;
  logic [2:0] stb_q;
  logic [2:0] stb_d;
  logic [CNT_W-1:0] cnt_q [3];
  logic [CNT_W-1:0] cnt_d [3];

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      sync1_q <= RST_V;
      sync2_q <= RST_V;
      stb_q   <= RST_V;
      for (int i = 0; i < 3; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      sync1_q <= {push_in, rot_b, rot_a};
      sync2_q <= sync1_q;
      stb_q   <= stb_d;
      for (int i = 0; i < 3; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  always_comb begin
    stb_d = stb_q;
    for (int i = 0; i < 3; i++) begin
      cnt_d[i] = '0;
      if (sync2_q[i] != stb_q[i]) begin
        if (cnt_q[i] == LAST) begin
          stb_d[i] = sync2_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + CNT_W'(1);
        end
      end
    end
  end

  logic [1:0] ab;
  state_e     state_q;
  state_e     state_d;
  logic       rotl_d;
  logic       rotr_d;
  logic       rotl_q;
  logic       rotr_q;
  logic       push_q;
  logic       pprev_q;

  assign ab = {stb_q[0], stb_q[1]};

  always_comb begin
    state_d = state_q;
    rotl_d  = 1'b0;
    rotr_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        case (ab)
          2'b01:   state_d = CW1;
          2'b10:   state_d = CCW1;
          2'b00:   state_d = ERR;
          default: state_d = IDLE;
        endcase
      end
      CW1: begin
        case (ab)
          2'b00:   state_d = CW2;
          2'b11:   state_d = IDLE;
          2'b10:   state_d = ERR;
          default: state_d = CW1;
        endcase
      end
      CW2: begin
        case (ab)
          2'b10:   state_d = CW3;
          2'b01:   state_d = CW1;
          2'b11:   state_d = ERR;
          default: state_d = CW2;
        endcase
      end
      CW3: begin
        case (ab)
          2'b11: begin
            state_d = IDLE;
            rotr_d  = 1'b1;
          end
          2'b00:   state_d = CW2;
          2'b01:   state_d = ERR;
          default: state_d = CW3;
        endcase
      end
      CCW1: begin
        case (ab)
          2'b00:   state_d = CCW2;
          2'b11:   state_d = IDLE;
          2'b01:   state_d = ERR;
          default: state_d = CCW1;
        endcase
      end
      CCW2: begin
        case (ab)
          2'b01:   state_d = CCW3;
          2'b10:   state_d = CCW1;
          2'b11:   state_d = ERR;
          default: state_d = CCW2;
        endcase
      end
      CCW3: begin
        case (ab)
          2'b11: begin
            state_d = IDLE;
            rotl_d  = 1'b1;
          end
          2'b00:   state_d = CCW2;
          2'b10:   state_d = ERR;
          default: state_d = CCW3;
        endcase
      end
      ERR: begin
        if (ab == 2'b11) state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state_q <= IDLE;
      rotl_q  <= 1'b0;
      rotr_q  <= 1'b0;
      push_q  <= 1'b0;
      pprev_q <= 1'b0;
    end else begin
      state_q <= state_d;
      rotl_q  <= rotl_d;
      rotr_q  <= rotr_d;
      push_q  <= stb_q[2] & ~pprev_q;
      pprev_q <= stb_q[2];
    end
  end

  assign rotl = rotl_q;
  assign rotr = rotr_q;
  assign push = push_q;

`ifdef ROTARY_DEC_POS_EN
  logic signed [7:0] pos_q;
  logic signed [7:0] pos_d;

  // Two's complement wrap is intentional
  always_comb begin
    pos_d = pos_q;
    if (rotr_d) pos_d = pos_q + 8'sd1;
    else if (rotl_d) pos_d = pos_q - 8'sd1;
  end

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) pos_q <= '0;
    else      pos_q <= pos_d;
  end

  assign pos = pos_q;
`endif

endmodule

// File: tb/tb_rotary_decoder.sv
// Bench for rotary_decoder: directed plan steps plus random pin traffic
// against a detent-counting reference model.
module tb_rotary_decoder;
  localparam int DEB = 4;

  logic clk = 1'b0;
  logic clr;
  logic rot_a;
  logic rot_b;
  logic push_in;
  logic rotl;
  logic rotr;
  logic push;
`ifdef ROTARY_DEC_POS_EN
  logic signed [7:0] pos;
`endif

  always #5 clk = ~clk;

  rotary_decoder #(.DEB_CYCLES(DEB), .CNT_W(16)) dut (
    .clk(clk),
    .clr(clr),
    .rot_a(rot_a),
    .rot_b(rot_b),
    .push_in(push_in),
    .rotl(rotl),
    .rotr(rotr),
    .push(push)
`ifdef ROTARY_DEC_POS_EN
    ,
    .pos(pos)
`endif
  );

  int errs = 0;
  int checks = 0;
  int ncyc = 0;
  int n_rotl = 0;
  int n_rotr = 0;
  int n_push = 0;
  int last_rotr = -1;
  int last_push = -1;

  // Reference model: pin history -> debounced level -> detent progress
  logic [2:0] m_s1, m_s2, m_stb;
  int m_run [3];
  int m_mode, m_dir, m_k, m_last;
  logic m_rotl, m_rotr, m_push, m_pprev;
  logic signed [7:0] m_pos;

  // Quadrature phase along the clockwise cycle 11,01,00,10
  function automatic int phase(input logic [1:0] ab);
    case (ab)
      2'b11:   return 0;
      2'b01:   return 1;
      2'b00:   return 2;
      default: return 3;
    endcase
  endfunction

  always @(posedge clk or negedge clr) begin : model
    int cur, dl, mode, dir, k, s;
    logic el, er;
    logic [2:0] nstb;
    int nrun [3];
    if (!clr) begin
      m_s1 <= 3'b011;
      m_s2 <= 3'b011;
      m_stb <= 3'b011;
      for (int i = 0; i < 3; i++) m_run[i] <= 0;
      m_mode <= 0;
      m_dir <= 0;
      m_k <= 0;
      m_last <= 0;
      m_rotl <= 1'b0;
      m_rotr <= 1'b0;
      m_push <= 1'b0;
      m_pprev <= 1'b0;
      m_pos <= '0;
    end else begin
      cur = phase({m_stb[0], m_stb[1]});
      dl = (cur - m_last + 4) % 4;
      mode = m_mode;
      dir = m_dir;
      k = m_k;
      el = 1'b0;
      er = 1'b0;
      if (mode == 2) begin
        if (cur == 0) mode = 0;
      end else if (dl == 2) begin
        mode = 2;
      end else if (dl != 0) begin
        s = (dl == 1) ? 1 : -1;
        if (mode == 0) begin
          mode = 1;
          dir = s;
          k = 1;
        end else if (s == dir) begin
          k = k + 1;
          if (k == 4) begin
            mode = 0;
            if (dir > 0) er = 1'b1;
            else el = 1'b1;
          end
        end else begin
          k = k - 1;
          if (k == 0) mode = 0;
        end
      end
      nstb = m_stb;
      for (int i = 0; i < 3; i++) begin
        nrun[i] = 0;
        if (m_s2[i] != m_stb[i]) begin
          if (m_run[i] + 1 >= DEB) nstb[i] = m_s2[i];
          else nrun[i] = m_run[i] + 1;
        end
      end
      m_mode <= mode;
      m_dir <= dir;
      m_k <= k;
      m_last <= cur;
      m_rotl <= el;
      m_rotr <= er;
      m_push <= m_stb[2] & ~m_pprev;
      m_pprev <= m_stb[2];
      if (er) m_pos <= m_pos + 8'sd1;
      else if (el) m_pos <= m_pos - 8'sd1;
      m_stb <= nstb;
      for (int i = 0; i < 3; i++) m_run[i] <= nrun[i];
      m_s2 <= m_s1;
      m_s1 <= {push_in, rot_b, rot_a};
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s got=%0d exp=%0d", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(negedge clk);
    ncyc++;
    chk("rotl", 32'(rotl), 32'(m_rotl));
    chk("rotr", 32'(rotr), 32'(m_rotr));
    chk("push", 32'(push), 32'(m_push));
    chk("rotl_rotr_excl", 32'(rotl & rotr), 32'd0);
`ifdef ROTARY_DEC_POS_EN
    chk("pos", 32'(pos), 32'(m_pos));
`endif
    if (rotl === 1'b1) n_rotl++;
    if (rotr === 1'b1) begin
      n_rotr++;
      last_rotr = ncyc;
    end
    if (push === 1'b1) begin
      n_push++;
      last_push = ncyc;
    end
  endtask

  task automatic hold(input logic a, input logic b, input logic p,
                      input int n);
    rot_a = a;
    rot_b = b;
    push_in = p;
    repeat (n) cyc();
  endtask

  task automatic do_reset(input int n);
    clr = 1'b0;
    repeat (n) cyc();
    clr = 1'b1;
  endtask

  initial begin
    int bl, br, bp, c0;
    int cur;
    logic [1:0] tab [4];
    tab[0] = 2'b11;
    tab[1] = 2'b01;
    tab[2] = 2'b00;
    tab[3] = 2'b10;
    clr = 1'b0;
    rot_a = 1'b1;
    rot_b = 1'b1;
    push_in = 1'b0;

    // Reset hold, then idle for 50 cycles
    repeat (5) cyc();
    chk("rst_rotl", 32'(rotl), 32'd0);
    chk("rst_rotr", 32'(rotr), 32'd0);
    chk("rst_push", 32'(push), 32'd0);
`ifdef ROTARY_DEC_POS_EN
    chk("rst_pos", 32'(pos), 32'd0);
`endif
    clr = 1'b1;
    repeat (50) cyc();
    chk("idle_pulses", 32'(n_rotl + n_rotr + n_push), 32'd0);

    // One clockwise detent
    bl = n_rotl;
    br = n_rotr;
    hold(1'b0, 1'b1, 1'b0, 10);
    hold(1'b0, 1'b0, 1'b0, 10);
    hold(1'b1, 1'b0, 1'b0, 10);
    c0 = ncyc;
    hold(1'b1, 1'b1, 1'b0, 20);
    chk("cw_rotr", 32'(n_rotr - br), 32'd1);
    chk("cw_rotl", 32'(n_rotl - bl), 32'd0);
    chk("cw_latency", 32'(last_rotr - c0), 32'(DEB + 3));
`ifdef ROTARY_DEC_POS_EN
    chk("cw_pos", 32'(pos), 32'd1);
`endif

    // 130 counter-clockwise detents from a fresh reset
    do_reset(3);
    bl = n_rotl;
    br = n_rotr;
    for (int i = 0; i < 130; i++) begin
      hold(1'b1, 1'b0, 1'b0, 10);
      hold(1'b0, 1'b0, 1'b0, 10);
      hold(1'b0, 1'b1, 1'b0, 10);
      hold(1'b1, 1'b1, 1'b0, 10);
    end
    chk("ccw_rotl", 32'(n_rotl - bl), 32'd130);
    chk("ccw_rotr", 32'(n_rotr - br), 32'd0);
`ifdef ROTARY_DEC_POS_EN
    chk("ccw_pos_wrap", 32'(pos), 32'(8'sd126));
`endif

    // Partial step with 3-cycle bounces on A
    bl = n_rotl;
    br = n_rotr;
    hold(1'b0, 1'b1, 1'b0, 10);
    hold(1'b1, 1'b1, 1'b0, 3);
    hold(1'b0, 1'b1, 1'b0, 10);
    hold(1'b0, 1'b0, 1'b0, 10);
    hold(1'b1, 1'b0, 1'b0, 3);
    hold(1'b0, 1'b0, 1'b0, 10);
    hold(1'b0, 1'b1, 1'b0, 10);
    hold(1'b1, 1'b1, 1'b0, 3);
    hold(1'b0, 1'b1, 1'b0, 10);
    hold(1'b1, 1'b1, 1'b0, 20);
    chk("partial_pulses", 32'(n_rotl - bl + n_rotr - br), 32'd0);

    // Double jump, then a clean clockwise detent
    hold(1'b0, 1'b0, 1'b0, 10);
    hold(1'b1, 1'b1, 1'b0, 10);
    chk("dbl_pulses", 32'(n_rotl - bl + n_rotr - br), 32'd0);
    hold(1'b0, 1'b1, 1'b0, 10);
    hold(1'b0, 1'b0, 1'b0, 10);
    hold(1'b1, 1'b0, 1'b0, 10);
    hold(1'b1, 1'b1, 1'b0, 20);
    chk("dbl_then_cw", 32'(n_rotr - br), 32'd1);

    // Push with 2-cycle chatter, release, then reset mid-press
    bp = n_push;
    hold(1'b1, 1'b1, 1'b1, 2);
    hold(1'b1, 1'b1, 1'b0, 2);
    hold(1'b1, 1'b1, 1'b1, 2);
    hold(1'b1, 1'b1, 1'b0, 2);
    c0 = ncyc;
    hold(1'b1, 1'b1, 1'b1, 20);
    chk("push_count", 32'(n_push - bp), 32'd1);
    chk("push_latency", 32'(last_push - c0), 32'(DEB + 3));
    hold(1'b1, 1'b1, 1'b0, 20);
    chk("release_pulse", 32'(n_push - bp), 32'd1);
    hold(1'b1, 1'b1, 1'b1, 3);
    clr = 1'b0;
    push_in = 1'b0;
    repeat (3) cyc();
    clr = 1'b1;
    repeat (20) cyc();
    chk("clr_midpress", 32'(n_push - bp), 32'd1);

    // Random pin traffic, mostly legal Gray moves
    cur = 0;
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 9) < 7)
        cur = ($urandom_range(0, 1) == 1) ? (cur + 1) % 4 : (cur + 3) % 4;
      else
        cur = int'($urandom_range(0, 3));
      hold(tab[cur][1], tab[cur][0], 1'($urandom_range(0, 1)),
           int'($urandom_range(1, 12)));
      if ($urandom_range(0, 49) == 0) do_reset(2);
    end
    hold(1'b1, 1'b1, 1'b0, 30);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
